// File: rtl/mac_vlg_pkg.sv
// Shared types and constants for the MAC receive path: stream beat, header,
// device info, and the demux state/port encodings.
package mac_vlg_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [47:0] MAC_BCAST      = 48'hffffffffffff;

    typedef struct packed {
        logic [47:0] dst_mac_addr;
        logic [47:0] src_mac_addr;
        logic [15:0] ethertype;
    } hdr_t;

    typedef struct packed {
        logic [47:0] mac_addr;
        logic [31:0] ip_addr;
    } dev_t;

    // One cycle of a mac stream; busy travels separately in the opposite direction.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       sof;
        logic       eof;
        logic       err;
        hdr_t       hdr;
    } mac_t;

    typedef enum logic [1:0] {idle_s, fwd_s, drop_s} demux_fsm_t;
    typedef enum logic {sel_ipv4, sel_arp} demux_sel_t;

endpackage

// File: rtl/mac_vlg_stat.sv
// Wrap-around event counter used for the receive frame statistics.
module mac_vlg_stat
    import mac_vlg_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    output logic [STAT_W-1:0] cnt_o
);

    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + STAT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_vlg_rx_demux.sv
// Receive demux: filters frames on destination MAC, steers them by ethertype to
// the IPv4 or ARP stream with one cycle of latency, and keeps frame statistics.
//
// state  | meaning
// idle_s | between frames, waiting for sof
// fwd_s  | forwarding an accepted frame to port sel_q
// drop_s | discarding the rest of a rejected or overlength frame
module mac_vlg_rx_demux
    import mac_vlg_pkg::*;
#(
    parameter bit PROMISC = 1'b0,
    parameter int MAX_LEN = 1500,
    parameter int STAT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  dev_t              dev_i,
    input  mac_t              rx_i,
    output logic              rx_busy_o,
    output mac_t              ipv4_o,
    input  logic              ipv4_busy_i,
    output mac_t              arp_o,
    input  logic              arp_busy_i,
    output logic [STAT_W-1:0] cnt_ok_o,
    output logic [STAT_W-1:0] cnt_drop_o,
    output logic [STAT_W-1:0] cnt_err_o
);

    localparam int              LEN_W   = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    demux_fsm_t       state_q;
    demux_sel_t       sel_q;
    logic [LEN_W-1:0] len_q;
    mac_t             port_q [2];

    demux_sel_t sel_d;
    logic       addr_ok;
    logic       type_ok;
    logic       accept;
    logic       cont;
    logic       abort_prev;
    logic       fin_err;
    logic       fin_ok;
    logic       overlen;
    logic       inc_ok;
    logic       inc_drop;
    logic       inc_err;
    logic       unused_in;

    always_comb begin
        addr_ok = PROMISC
               || (rx_i.hdr.dst_mac_addr == dev_i.mac_addr)
               || (rx_i.hdr.dst_mac_addr == MAC_BCAST);
        type_ok = 1'b1;
        sel_d   = sel_ipv4;
        case (rx_i.hdr.ethertype)
            ETHERTYPE_IPV4: sel_d   = sel_ipv4;
            ETHERTYPE_ARP:  sel_d   = sel_arp;
            default:        type_ok = 1'b0;
        endcase
    end

    assign accept     = addr_ok && type_ok;
    assign cont       = (state_q == fwd_s) && !rx_i.sof;
    assign abort_prev = (state_q == fwd_s) && rx_i.sof;
    // err has priority over a coinciding eof
    assign fin_err    = cont && rx_i.err;
    assign fin_ok     = cont && !rx_i.err && rx_i.eof;
    assign overlen    = cont && !rx_i.err && !rx_i.eof && rx_i.v && (len_q == LEN_MAX);

    assign inc_ok     = fin_ok;
    assign inc_drop   = rx_i.sof && !accept;
    assign inc_err    = abort_prev || fin_err || overlen;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= idle_s;
            sel_q     <= sel_ipv4;
            len_q     <= '0;
            port_q[0] <= '0;
            port_q[1] <= '0;
        end else begin
            port_q[0].d   <= '0;
            port_q[0].v   <= 1'b0;
            port_q[0].sof <= 1'b0;
            port_q[0].eof <= 1'b0;
            port_q[0].err <= 1'b0;
            port_q[1].d   <= '0;
            port_q[1].v   <= 1'b0;
            port_q[1].sof <= 1'b0;
            port_q[1].eof <= 1'b0;
            port_q[1].err <= 1'b0;

            if (fin_err) begin
                port_q[sel_q].err <= 1'b1;
                state_q           <= idle_s;
            end else if (fin_ok) begin
                port_q[sel_q].eof <= 1'b1;
                state_q           <= idle_s;
            end else if (overlen) begin
                port_q[sel_q].err <= 1'b1;
                state_q           <= drop_s;
            end else if (cont) begin
                port_q[sel_q].d <= rx_i.d;
                port_q[sel_q].v <= rx_i.v;
                if (rx_i.v) begin
                    len_q <= len_q + LEN_W'(1);
                end
            end

            if (abort_prev) begin
                port_q[sel_q].err <= 1'b1;
            end

            // A new sof is judged in every state; a truncated frame was closed above.
            if (rx_i.sof) begin
                if (accept) begin
                    state_q           <= fwd_s;
                    sel_q             <= sel_d;
                    len_q             <= LEN_W'(1);
                    port_q[sel_d].d   <= rx_i.d;
                    port_q[sel_d].v   <= rx_i.v;
                    port_q[sel_d].sof <= 1'b1;
                    port_q[sel_d].hdr <= rx_i.hdr;
                end else begin
                    state_q <= drop_s;
                end
            end else if ((state_q == drop_s) && (rx_i.eof || rx_i.err)) begin
                state_q <= idle_s;
            end
        end
    end

    assign ipv4_o    = port_q[sel_ipv4];
    assign arp_o     = port_q[sel_arp];
    assign rx_busy_o = 1'b0;
    assign unused_in = ^{ipv4_busy_i, arp_busy_i, dev_i.ip_addr};

    mac_vlg_stat #(.STAT_W(STAT_W)) u_stat_ok (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (inc_ok),
        .cnt_o (cnt_ok_o)
    );

    mac_vlg_stat #(.STAT_W(STAT_W)) u_stat_drop (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (inc_drop),
        .cnt_o (cnt_drop_o)
    );

    mac_vlg_stat #(.STAT_W(STAT_W)) u_stat_err (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (inc_err),
        .cnt_o (cnt_err_o)
    );

endmodule

// File: tb/tb_mac_vlg_rx_demux.sv
// Bench for mac_vlg_rx_demux: a frame-level schedule is built up front together
// with the per-cycle outputs each frame must produce, then played and compared.
module tb_mac_vlg_rx_demux;
    import mac_vlg_pkg::*;

    localparam int          MAXL  = 64;
    localparam int          STW   = 4;
    localparam int          NCYC  = 6000;
    localparam logic [47:0] OWN   = 48'h020000000001;
    localparam logic [47:0] BCAST = 48'hffffffffffff;

    localparam int P_OK = 0, P_DROP = 1, P_ERR = 2, P_V4D = 3, P_V4SOF = 4, P_V4ERR = 5;
    localparam int P_V4EOF = 6, P_V4V = 7, P_ARPET = 8, P_ARPSOF = 9;

    logic           clk = 1'b0;
    logic           rst;
    dev_t           dev;
    mac_t           rx;
    logic           rx_busy;
    mac_t           ipv4;
    logic           ipv4_busy;
    mac_t           arp;
    logic           arp_busy;
    logic [STW-1:0] cnt_ok;
    logic [STW-1:0] cnt_drop;
    logic [STW-1:0] cnt_err;

    always #5 clk = ~clk;

    mac_vlg_rx_demux #(.PROMISC(1'b0), .MAX_LEN(MAXL), .STAT_W(STW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dev_i       (dev),
        .rx_i        (rx),
        .rx_busy_o   (rx_busy),
        .ipv4_o      (ipv4),
        .ipv4_busy_i (ipv4_busy),
        .arp_o       (arp),
        .arp_busy_i  (arp_busy),
        .cnt_ok_o    (cnt_ok),
        .cnt_drop_o  (cnt_drop),
        .cnt_err_o   (cnt_err)
    );

    // input schedule
    bit [7:0] s_d   [NCYC];
    bit       s_v   [NCYC];
    bit       s_sof [NCYC];
    bit       s_eof [NCYC];
    bit       s_err [NCYC];
    bit       s_rst [NCYC];
    hdr_t     s_hdr [NCYC];
    // expected outputs per port (0 = ipv4, 1 = arp), indexed by input cycle
    bit [7:0] e_d   [2][NCYC];
    bit       e_v   [2][NCYC];
    bit       e_sof [2][NCYC];
    bit       e_eof [2][NCYC];
    bit       e_err [2][NCYC];
    bit       e_ld  [2][NCYC];
    int       e_dok   [NCYC];
    int       e_ddrop [NCYC];
    int       e_derr  [NCYC];

    int pin_cyc [$];
    int pin_sig [$];
    int pin_val [$];

    int   wp;
    int   pend;
    int   cur = -1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_ok = 0, m_drop = 0, m_err = 0;
    hdr_t m_hdr [2];

    task automatic pin(input int c, input int sig, input int val);
        pin_cyc.push_back(c);
        pin_sig.push_back(sig);
        pin_val.push_back(val);
    endtask

    // kind: 0 eof, 1 err, 2 eof+err together, 3 cut short by the next frame's sof
    task automatic add_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                             input int kind, input int rst_at, input bit pat, input int gap);
        hdr_t h;
        int   p;
        int   s;
        int   e;
        bit   acc;
        h.dst_mac_addr = dst;
        h.src_mac_addr = {16'h0a00, 32'($urandom)};
        h.ethertype    = et;
        p   = (et == 16'h0800) ? 0 : (et == 16'h0806) ? 1 : -1;
        acc = ((dst == OWN) || (dst == BCAST)) && (p >= 0);
        s   = wp;
        if (pend >= 0) begin
            e_err[pend][s] = 1'b1;
            e_derr[s]++;
            pend = -1;
        end
        for (int i = 0; i < len; i++) begin
            int c;
            bit alive;
            c        = s + i;
            s_v[c]   = 1'b1;
            s_sof[c] = (i == 0);
            s_hdr[c] = h;
            s_d[c]   = pat ? 8'(i + 1) : 8'($urandom);
            if (i == rst_at) s_rst[c] = 1'b1;
            alive = (rst_at < 0) || (i < rst_at);
            if (acc && alive && i < MAXL) begin
                e_v[p][c]   = 1'b1;
                e_d[p][c]   = s_d[c];
                e_sof[p][c] = (i == 0);
            end
            if (acc && alive && i == MAXL) begin
                e_err[p][c] = 1'b1;
                e_derr[c]++;
            end
            if (i == 0) begin
                if (acc) e_ld[p][c] = 1'b1;
                else     e_ddrop[c]++;
            end
        end
        e = s + len;
        if (kind == 3) begin
            if (acc && len <= MAXL && rst_at < 0) pend = p;
            wp = e;
            return;
        end
        s_hdr[e] = h;
        s_eof[e] = (kind == 0) || (kind == 2);
        s_err[e] = (kind != 0);
        if (acc && len <= MAXL && rst_at < 0) begin
            if (kind == 0) begin
                e_eof[p][e] = 1'b1;
                e_dok[e]++;
            end else begin
                e_err[p][e] = 1'b1;
                e_derr[e]++;
            end
        end
        wp = e + 1;
        for (int g = 0; g < gap; g++) begin
            s_v[wp + g]   = 1'($urandom_range(0, 1));
            s_d[wp + g]   = 8'($urandom);
            s_hdr[wp + g] = h;
        end
        wp = wp + gap;
    endtask

    task automatic chk(input string nm, input int c, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        else n_pass++;
    endtask

    function automatic int pin_actual(input int sig);
        case (sig)
            P_OK:     return int'(cnt_ok);
            P_DROP:   return int'(cnt_drop);
            P_ERR:    return int'(cnt_err);
            P_V4D:    return int'(ipv4.d);
            P_V4SOF:  return int'(ipv4.sof);
            P_V4ERR:  return int'(ipv4.err);
            P_V4EOF:  return int'(ipv4.eof);
            P_V4V:    return int'(ipv4.v);
            P_ARPET:  return int'(arp.hdr.ethertype);
            P_ARPSOF: return int'(arp.sof);
            default:  return -1;
        endcase
    endfunction

    task automatic check_cycle(input int c);
        mac_t got [2];
        got[0] = ipv4;
        got[1] = arp;
        if (s_rst[c]) begin
            m_ok     = 0;
            m_drop   = 0;
            m_err    = 0;
            m_hdr[0] = '0;
            m_hdr[1] = '0;
        end else begin
            m_ok   = (m_ok + e_dok[c]) % (1 << STW);
            m_drop = (m_drop + e_ddrop[c]) % (1 << STW);
            m_err  = (m_err + e_derr[c]) % (1 << STW);
            for (int p = 0; p < 2; p++) if (e_ld[p][c]) m_hdr[p] = s_hdr[c];
        end
        for (int p = 0; p < 2; p++) begin
            logic [3:0] ectl;
            string      nm;
            nm   = (p == 0) ? "ipv4" : "arp";
            ectl = s_rst[c] ? 4'b0 : {e_v[p][c], e_sof[p][c], e_eof[p][c], e_err[p][c]};
            chk({nm, "_ctl"}, c, 128'({got[p].v, got[p].sof, got[p].eof, got[p].err}), 128'(ectl));
            if (ectl[3]) chk({nm, "_d"}, c, 128'(got[p].d), 128'(e_d[p][c]));
            chk({nm, "_hdr"}, c, 128'(got[p].hdr), 128'(m_hdr[p]));
        end
        chk("cnt_ok", c, 128'(cnt_ok), 128'(m_ok));
        chk("cnt_drop", c, 128'(cnt_drop), 128'(m_drop));
        chk("cnt_err", c, 128'(cnt_err), 128'(m_err));
        chk("rx_busy", c, 128'(rx_busy), 128'(0));
        for (int i = 0; i < pin_cyc.size(); i++) begin
            if (pin_cyc[i] == c) chk($sformatf("pin%0d", pin_sig[i]), c, 128'(pin_actual(pin_sig[i])), 128'(pin_val[i]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (cur >= 0) check_cycle(cur);
    end

    initial begin
        int s;
        int nlast;
        rst       = 1'b1;
        rx        = '0;
        ipv4_busy = 1'b0;
        arp_busy  = 1'b0;
        dev       = '{mac_addr: OWN, ip_addr: 32'hc0a80001};
        for (int c = 0; c < NCYC; c++) s_hdr[c] = '0;
        pend = -1;
        for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
        pin(2, P_OK, 0);
        pin(2, P_DROP, 0);
        pin(2, P_ERR, 0);
        wp = 5;

        s = wp; add_frame(OWN, 16'h0800, 46, 0, -1, 1'b1, 3);
        pin(s, P_V4D, 1); pin(s, P_V4SOF, 1); pin(s + 45, P_V4D, 46);
        pin(s + 46, P_V4EOF, 1); pin(s + 46, P_OK, 1);
        s = wp; add_frame(BCAST, 16'h0806, 28, 0, -1, 1'b1, 3);
        pin(s, P_ARPET, 16'h0806); pin(s + 28, P_OK, 2);
        add_frame(48'h020000000099, 16'h0800, 20, 0, -1, 1'b1, 2);
        s = wp; add_frame(OWN, 16'h86dd, 20, 0, -1, 1'b1, 2);
        pin(s, P_DROP, 2);
        s = wp; add_frame(OWN, 16'h0800, 100, 0, -1, 1'b1, 3);
        pin(s + 63, P_V4D, 64); pin(s + 64, P_V4ERR, 1); pin(s + 64, P_ERR, 1);
        pin(s + 100, P_V4EOF, 0); pin(s + 100, P_OK, 2);
        s = wp; add_frame(OWN, 16'h0800, 64, 0, -1, 1'b1, 3);
        pin(s + 63, P_V4D, 64); pin(s + 64, P_OK, 3);
        s = wp; add_frame(OWN, 16'h0800, 65, 0, -1, 1'b1, 3);
        pin(s + 64, P_ERR, 2); pin(s + 65, P_OK, 3);
        add_frame(OWN, 16'h0800, 20, 3, -1, 1'b1, 0);
        s = wp; add_frame(BCAST, 16'h0806, 10, 0, -1, 1'b1, 3);
        pin(s, P_V4ERR, 1); pin(s, P_ARPSOF, 1); pin(s, P_ERR, 3); pin(s + 10, P_OK, 4);
        s = wp; add_frame(OWN, 16'h0800, 30, 0, 10, 1'b1, 3);
        pin(s + 9, P_V4D, 10); pin(s + 10, P_OK, 0); pin(s + 10, P_ERR, 0); pin(s + 11, P_V4V, 0);
        s = wp; add_frame(OWN, 16'h0800, 12, 0, -1, 1'b1, 3);
        pin(s, P_V4SOF, 1); pin(s + 12, P_OK, 1);

        while (wp < NCYC - 200) begin
            int          r;
            int          len;
            int          kind;
            int          rat;
            logic [47:0] dst;
            logic [15:0] et;
            r    = $urandom_range(0, 99);
            dst  = (r < 45) ? OWN : (r < 70) ? BCAST : {16'h0a00, 32'($urandom)};
            r    = $urandom_range(0, 99);
            et   = (r < 45) ? 16'h0800 : (r < 80) ? 16'h0806 : (r < 90) ? 16'h86dd
                 : 16'($urandom_range(0, 16'h07ff));
            len  = $urandom_range(1, 80);
            kind = $urandom_range(0, 3);
            rat  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
            add_frame(dst, et, len, kind, rat, 1'b0, (kind == 3) ? 0 : $urandom_range(0, 4));
        end
        add_frame(OWN, 16'h0800, 8, 0, -1, 1'b0, 4);
        nlast = wp;

        for (int c = 0; c < nlast; c++) begin
            @(negedge clk);
            rst       = s_rst[c];
            rx.d      = s_d[c];
            rx.v      = s_v[c];
            rx.sof    = s_sof[c];
            rx.eof    = s_eof[c];
            rx.err    = s_err[c];
            rx.hdr    = s_hdr[c];
            ipv4_busy = 1'($urandom_range(0, 1));
            arp_busy  = 1'($urandom_range(0, 1));
            cur       = c;
        end
        @(negedge clk);
        cur = -1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_vlg_rx_demux.md
Name: mac_vlg_rx_demux

Overview:
Sits directly downstream of the MAC receive stage and consumes its mac stream (d/v/sof/eof/err/hdr).
- Filters frames on destination address: own address or broadcast, or any address when promiscuous.
- Steers accepted frames by ethertype to an IPv4 or an ARP mac stream.
- Enforces a maximum payload length.
- Keeps wrap-around frame statistics.
- Adds one cycle of latency, with no backpressure.

Parameters:
PROMISC, 0, 1 = accept any destination MAC.
MAX_LEN, 1500, maximum payload bytes per frame; byte MAX_LEN+1 aborts the frame.
STAT_W, 16, width of each statistics counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
dev  input  dev_t  local device info; uses dev.mac_addr
rx  mac.in  -  frame stream from MAC receive; rx.busy is driven 0
ipv4  mac.out  -  frames with ethertype 16'h0800; ipv4.busy is ignored
arp  mac.out  -  frames with ethertype 16'h0806; arp.busy is ignored
cnt_ok  output  STAT_W  frames forwarded and terminated by eof
cnt_drop  output  STAT_W  frames dropped by address or ethertype filter
cnt_err  output  STAT_W  frames terminated by err, overlength, or sof-before-eof

Behaviour:
Reset (synchronous, rst=1):
- All output fields go to 0: d, v, sof, eof, err and hdr on both ports; all three counters.
- FSM goes to idle_s.
- Reset mid-frame: the remainder of that frame is ignored, because v without sof is discarded in idle_s.

Input contract:
- rx.sof pulses together with the first rx.v byte.
- rx.hdr is stable from sof until eof/err.
- rx.eof or rx.err is a single-cycle pulse ending the frame.

Accept rule, evaluated on rx.sof:
- Address: rx.hdr.dst_mac_addr == dev.mac_addr, or == 48'hffffffffffff, or PROMISC=1.
- Ethertype: 16'h0800 selects ipv4; 16'h0806 selects arp; anything else drops.

FSM:
- idle_s:
  - rx.sof & accept → fwd_s; latch the selected port in sel.
  - rx.sof & !accept → drop_s; cnt_drop+1.
  - All other inputs are ignored.
- fwd_s, outputs on port sel, each registered one cycle after the input:
  - sel.d = rx.d and sel.v = rx.v.
  - sel.sof = rx.sof, only on the cycle the frame was accepted.
  - sel.hdr is loaded from rx.hdr at sof and held until the frame ends.
  - Payload bytes are counted while v=1, starting at 1 with the sof byte.
  - rx.eof → sel.eof=1, v=0 next cycle; cnt_ok+1; go to idle_s.
  - rx.err → sel.err=1, v=0; cnt_err+1; go to idle_s.
  - Byte count reaches MAX_LEN+1 → sel.err=1, v=0 on that output cycle (the byte is not forwarded); cnt_err+1; go to drop_s.
  - rx.sof without a prior eof/err → previous frame gets sel.err=1; cnt_err+1; the new frame is evaluated in the same cycle with the accept rule.
- drop_s:
  - rx.eof or rx.err → idle_s; no further count.
  - rx.sof → evaluated as in idle_s.
- The non-selected port holds all zeros, except hdr, which keeps its last value.
- eof and err are never both asserted on an output. If they coincide on input, err wins and only cnt_err counts.
- Counters wrap modulo 2^STAT_W.

Latency:
- Exactly 1 clk from rx to the selected port for d, v, sof, eof and err.
- hdr is valid at the output sof cycle.

Decomposition:
- Add to mac_vlg_pkg:
  - ETHERTYPE_IPV4 = 16'h0800.
  - ETHERTYPE_ARP = 16'h0806.
  - MAC_BCAST = 48'hffffffffffff.
  - demux_fsm_t {idle_s, fwd_s, drop_s}.
  - demux_sel_t {sel_ipv4, sel_arp}.
- One natural sub-module, mac_vlg_stat: a STAT_W wrap-around counter with inc and rst ports, instantiated three times.
- Everything else stays flat.

Test Plan:
- Unicast to dev.mac_addr 02:00:00:00:00:01, ethertype 0800, 46-byte payload, eof → ipv4 sof/v at cycle+1; 46 bytes identical; eof 1 cycle after rx.eof; arp stays idle; cnt_ok=1.
- Broadcast ARP frame, 28 bytes → arp port carries frame with hdr.ethertype=16'h0806; cnt_ok=1; ipv4.v never high.
- Dst 02:00:00:00:00:99 with PROMISC=0, then ethertype 86DD to own MAC → no output v on either port; cnt_drop=2.
- MAX_LEN=64 with a 100-byte IPv4 frame → 64 bytes forwarded, err on the 65th output cycle, no eof; cnt_err=1; next good frame forwarded normally.
- Frame in progress, then rx.sof of a new ARP frame without eof → ipv4.err pulses; arp.sof on the following cycle; cnt_err=1; after the second eof, cnt_ok=1.
- rst asserted mid-IPv4 frame for 1 cycle → all outputs 0 next cycle; remaining bytes not forwarded; counters 0; the next frame is accepted.
